// File: rtl/icache_lookup_pkg.sv
// Shared geometry and record types for the fetch-stage I-cache lookup.
// Address split: tag = addr[31:8], index = addr[7:4], offset = addr[3:0].
package icache_lookup_pkg;

   localparam int SETS   = 16;
   localparam int WAYS   = 8;
   localparam int TAG_W  = 24;
   localparam int LINE_W = 128;
   localparam int IDX_W  = $clog2(SETS);
   localparam int WAY_W  = $clog2(WAYS);
   localparam int IDX_LO = 4;
   localparam int TAG_LO = IDX_LO + IDX_W;

   typedef struct packed {
      logic [31:0] pc;
      logic        pvalid;
      logic        ptaken;
      logic [31:0] ptarget;
   } fetch_req_t;

endpackage

// File: rtl/icache_lookup_if.sv
// Bus bundle for icache_lookup: fetch request in, held request out, refill/redirect from result_drive.
interface icache_lookup_if;
   import icache_lookup_pkg::*;

   logic              valid_pre_i;
   logic              ready_pre_o;
   logic [31:0]       pc_i;
   logic              pvalid_i;
   logic              ptaken_i;
   logic [31:0]       ptarget_i;
   logic              valid_post_o;
   logic              ready_post_i;
   logic              tar_hit_o;
   logic [LINE_W-1:0] buffer_o;
   logic [31:0]       araddr_o;
   logic              pvalid_o;
   logic              ptaken_o;
   logic [31:0]       ptarget_o;
   logic              flush_i;
   logic              wen_i;
   logic [IDX_W-1:0]  windex_i;
   logic [WAY_W-1:0]  wway_i;
   logic [TAG_W-1:0]  wtag_i;
   logic [LINE_W-1:0] wdata_i;
   logic              fence_i_i;

   modport slave (
      input  valid_pre_i, pc_i, pvalid_i, ptaken_i, ptarget_i, ready_post_i,
      input  flush_i, wen_i, windex_i, wway_i, wtag_i, wdata_i, fence_i_i,
      output ready_pre_o, valid_post_o, tar_hit_o, buffer_o, araddr_o,
      output pvalid_o, ptaken_o, ptarget_o
   );

   modport master (
      output valid_pre_i, pc_i, pvalid_i, ptaken_i, ptarget_i, ready_post_i,
      output flush_i, wen_i, windex_i, wway_i, wtag_i, wdata_i, fence_i_i,
      input  ready_pre_o, valid_post_o, tar_hit_o, buffer_o, araddr_o,
      input  pvalid_o, ptaken_o, ptarget_o
   );

endinterface

// File: rtl/icache_lookup_way.sv
// One cache way: SETS x (valid, tag, line), single write port, async read by index, hit compare.
module icache_lookup_way
   import icache_lookup_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              inval,
   input  logic              wen,
   input  logic [IDX_W-1:0]  windex,
   input  logic [TAG_W-1:0]  wtag,
   input  logic [LINE_W-1:0] wdata,
   input  logic [IDX_W-1:0]  rindex,
   input  logic [TAG_W-1:0]  rtag,
   output logic              hit,
   output logic [LINE_W-1:0] rdata
);

   logic [SETS-1:0]             valid_q;
   logic [SETS-1:0][TAG_W-1:0]  tag_q;
   logic [SETS-1:0][LINE_W-1:0] data_q;

   // Invalidate wins over a same-cycle refill so a fenced line never survives.
   always_ff @(posedge clock) begin
      if (reset)      valid_q         <= '0;
      else if (inval) valid_q         <= '0;
      else if (wen)   valid_q[windex] <= 1'b1;
   end

   always_ff @(posedge clock) begin
      if (wen) begin
         tag_q[windex]  <= wtag;
         data_q[windex] <= wdata;
      end
   end

   assign hit   = valid_q[rindex] && (tag_q[rindex] == rtag);
   assign rdata = data_q[rindex];

endmodule

// File: rtl/icache_lookup.sv
// Fetch-stage I-cache lookup: one-entry request register plus WAYS-wide tag compare and line mux.
// Define ICACHE_INVALIDATE_EN to let fence_i_i clear every valid bit.
module icache_lookup
   import icache_lookup_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   icache_lookup_if.slave  bus
);

   logic       valid_q;
   fetch_req_t req_q;
   logic       ready;
   logic       accept;
   logic       inval;

   assign ready  = !valid_q || bus.ready_post_i;
   assign accept = bus.valid_pre_i && ready;

   // Flush beats both accept and hold; payload may load on a flushed accept but stays invalid.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= 1'b0;
         req_q   <= '0;
      end else begin
         if (bus.flush_i)           valid_q <= 1'b0;
         else if (accept)           valid_q <= 1'b1;
         else if (bus.ready_post_i) valid_q <= 1'b0;
         if (accept)
            req_q <= '{pc: bus.pc_i, pvalid: bus.pvalid_i,
                       ptaken: bus.ptaken_i, ptarget: bus.ptarget_i};
      end
   end

`ifdef ICACHE_INVALIDATE_EN
   assign inval = bus.fence_i_i;
`else
   assign inval = 1'b0;
   wire unused_fence = bus.fence_i_i;
`endif

   // Offset selects a word downstream; only index and tag matter here.
   wire unused_offset = ^req_q.pc[IDX_LO-1:0];

   logic [IDX_W-1:0]             rindex;
   logic [TAG_W-1:0]             rtag;
   logic [WAYS-1:0]              way_hit;
   logic [WAYS-1:0][LINE_W-1:0]  way_data;

   assign rindex = req_q.pc[IDX_LO +: IDX_W];
   assign rtag   = req_q.pc[TAG_LO +: TAG_W];

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      icache_lookup_way u_way (
         .clock  (clock),
         .reset  (reset),
         .inval  (inval),
         .wen    (bus.wen_i && (bus.wway_i == WAY_W'(w))),
         .windex (bus.windex_i),
         .wtag   (bus.wtag_i),
         .wdata  (bus.wdata_i),
         .rindex (rindex),
         .rtag   (rtag),
         .hit    (way_hit[w]),
         .rdata  (way_data[w])
      );
   end

   // Scan high to low so the lowest hitting way ends up selected.
   logic [LINE_W-1:0] line;
   always_comb begin
      line = '0;
      for (int w = WAYS - 1; w >= 0; w--)
         if (way_hit[w]) line = way_data[w];
   end

   assign bus.ready_pre_o  = ready;
   assign bus.valid_post_o = valid_q;
   assign bus.tar_hit_o    = |way_hit;
   assign bus.buffer_o     = line;
   assign bus.araddr_o     = req_q.pc;
   assign bus.pvalid_o     = req_q.pvalid;
   assign bus.ptaken_o     = req_q.ptaken;
   assign bus.ptarget_o    = req_q.ptarget;

endmodule
